writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//   Write-side counterpart of the fetch stage. Accepts computed vector elements
//   from the Euler update datapath through a valid/ready handshake. Buffers them
//   in a small FIFO and writes them sequentially into the vector region of RAM
//   (base VEC_BASE) through the RAM write port. Signals completion of each full
//   vector so the controller can restart fetching for the next step.
// PARAMETERS
//   ADD_SIZE   16  RAM address width
//   DATA_SIZE  16  data word width
//   VEC_BASE   5   first RAM address of the state vector (matches fetch vector base)
//   VEC_LEN    4   elements per vector, 1..2^ADD_SIZE-VEC_BASE
//   FIFO_DEPTH 4   input buffer depth, power of two, >=2
// PORTS
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous, active-low reset
//   init_start in   1          sync restart: flush FIFO, address back to VEC_BASE
//   in_valid   in   1          in_data holds a valid element
//   in_data    in   DATA_SIZE  computed element, in vector order
//   in_ready   out  1          element accepted on a clock edge with in_valid&in_ready
//   mem_grant  in   1          RAM write port free this cycle (fetch has priority)
//   mem_we     out  1          RAM write enable
//   mem_waddr  out  ADD_SIZE   RAM write address
//   mem_wdata  out  DATA_SIZE  RAM write data
//   vec_done   out  1          one-cycle pulse after the last element of a vector is written
//   busy       out  1          FIFO non-empty or state != IDLE
// BEHAVIOUR
//   Reset (reset=0, async):
//   - FIFO empty; wr_cnt=0; state=IDLE; vec_done=0.
//   - Outputs: in_ready=1, mem_we=0, mem_waddr=VEC_BASE, mem_wdata=0 (FIFO storage cleared), busy=0.
//   FIFO:
//   - in_ready = !full & !init_start.
//   - Push when in_valid&in_ready; pop when mem_we. Push and pop may occur in the same cycle.
//   - When full, in_ready=0 and in_valid is ignored. Data must be held by the sender.
//   - Element latency: an element pushed at edge N may be written at edge N+1 at the earliest.
//   FSM states:
//   - IDLE:  go to WRITE when the FIFO is non-empty.
//   - WRITE: mem_we = !empty & mem_grant (combinational).
//     mem_waddr = VEC_BASE + wr_cnt; mem_wdata = FIFO head.
//     On each write edge, wr_cnt increments. When wr_cnt==VEC_LEN-1 on a write
//     edge: wr_cnt wraps to 0 and go to DONE.
//     If empty with wr_cnt!=VEC_LEN-1, stay in WRITE with mem_we=0.
//   - DONE:  vec_done=1 (registered, exactly 1 cycle); mem_we=0; then go to IDLE.
//     Pushes are still accepted in DONE.
//   Rules:
//   - mem_grant=0 stalls the write. Address and data hold, nothing is lost.
//   - Address arithmetic is ADD_SIZE-bit unsigned, with no overflow inside the vector region.
//   - init_start has priority over everything:
//     - next edge: FIFO flushed, wr_cnt=0, state=IDLE, vec_done=0;
//     - mem_we forced 0 in that cycle;
//     - an element offered in that cycle is not accepted.
//   - Async reset mid-vector discards buffered and partially written data. RAM
//     contents already written remain.
//   - VEC_LEN=1: every write goes to DONE, producing one vec_done per element.
// TESTING
//   1. Reset, then push 4 elements 0x0011..0x0044 back-to-back with mem_grant=1
//      -> writes to addrs 5,6,7,8 on consecutive cycles; vec_done pulses once,
//      one cycle after addr 8 is written.
//   2. Push 6 elements with mem_grant=0 -> in_ready drops after 4 accepted;
//      raise mem_grant -> remaining elements accepted, and all 6 are written in order
//      (addrs 5-8, then 5-6 of the next vector).
//   3. Toggle mem_grant 1,0,1,0 during a vector -> mem_waddr/mem_wdata hold while
//      grant=0; no duplicate or skipped address.
//   4. Assert init_start after 2 of 4 writes -> next element written to addr 5;
//      no vec_done for the aborted vector.
//   5. Drop reset low mid-WRITE with 3 elements buffered -> all outputs immediately
//      at reset values; busy=0.
//   6. VEC_LEN=1: push 0xAAAA, then 0xBBBB -> both written to addr 5, with a
//      vec_done after each write.

Source files
------------

// File: rtl/writeback_stage.sv
`default_nettype none
// =============================================================================
// Module   : writeback_stage
// Purpose  : Buffers computed vector elements in a small FIFO and writes them
//            sequentially into the RAM vector region, flagging each full vector.
// Revision : 1.0 - initial release
// =============================================================================
module writeback_stage #(
  parameter int ADD_SIZE   = 16,
  parameter int DATA_SIZE  = 16,
  parameter int VEC_BASE   = 5,
  parameter int VEC_LEN    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_start,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 in_ready,
  input  logic                 mem_grant,
  output logic                 mem_we,
  output logic [ADD_SIZE-1:0]  mem_waddr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic                 vec_done,
  output logic                 busy
);

  localparam int                  c_ptr_w     = $clog2(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]    c_depth     = (c_ptr_w + 1)'(FIFO_DEPTH);
  localparam logic [ADD_SIZE-1:0] c_vec_base  = ADD_SIZE'(VEC_BASE);
  localparam logic [ADD_SIZE-1:0] c_last_idx  = ADD_SIZE'(VEC_LEN - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_write = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  logic [DATA_SIZE-1:0] r_fifo [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w:0]     r_count;
  logic [ADD_SIZE-1:0]  r_wr_cnt;
  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_we;
  logic w_last;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);
  assign w_push  = in_valid && !w_full && !init_start;
  assign w_we    = (r_state == c_st_write) && !w_empty && mem_grant && !init_start;
  assign w_last  = (r_wr_cnt == c_last_idx);

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (init_start) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_we)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_we})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_cnt <= '0;
    end else if (init_start) begin
      r_wr_cnt <= '0;
    end else if (w_we) begin
      r_wr_cnt <= w_last ? '0 : r_wr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (!w_empty) w_state_nxt = c_st_write;
      c_st_write: if (w_we && w_last) w_state_nxt = c_st_done;
      c_st_done:  w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
    if (init_start) w_state_nxt = c_st_idle;
  end

  // vec_done decodes the DONE state register, so it is a clean one-cycle pulse.
  always_comb begin
    in_ready  = !w_full && !init_start;
    mem_we    = w_we;
    mem_waddr = c_vec_base + r_wr_cnt;
    mem_wdata = r_fifo[r_rd_ptr];
    vec_done  = (r_state == c_st_done);
    busy      = !w_empty || (r_state != c_st_idle);
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// =============================================================================
// Module   : tb_writeback_stage
// Purpose  : Self-checking bench for writeback_stage against a queue-based model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_writeback_stage;

  localparam int AW = 16, DW = 16, BASE = 5, LEN = 4, DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init_start, in_valid, in_ready, mem_grant, mem_we, vec_done, busy;
  logic [DW-1:0] in_data, mem_wdata;
  logic [AW-1:0] mem_waddr;

  logic          in_valid1, in_ready1, mem_we1, vec_done1, busy1;
  logic [DW-1:0] in_data1, mem_wdata1;
  logic [AW-1:0] mem_waddr1;

  always #5 clk = ~clk;

  writeback_stage #(.ADD_SIZE(AW), .DATA_SIZE(DW), .VEC_BASE(BASE), .VEC_LEN(LEN),
                    .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .init_start(init_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_grant(mem_grant), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .vec_done(vec_done), .busy(busy));

  writeback_stage #(.ADD_SIZE(AW), .DATA_SIZE(DW), .VEC_BASE(BASE), .VEC_LEN(1),
                    .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(reset), .init_start(1'b0), .in_valid(in_valid1),
    .in_data(in_data1), .in_ready(in_ready1), .mem_grant(1'b1), .mem_we(mem_we1),
    .mem_waddr(mem_waddr1), .mem_wdata(mem_wdata1), .vec_done(vec_done1), .busy(busy1));

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted elements in order, element index since last flush.
  logic [DW-1:0] mq[$];
  int            idx = 0, cyc = 0, wr_total = 0, acc_total = 0, vd_cnt = 0, vd_cyc = 0;
  int            wr_cyc[$];
  bit            exp_vd = 1'b0;
  logic [AW-1:0] last_waddr = '0;
  logic [DW-1:0] last_wdata = '0;

  always @(negedge clk) begin
    bit rdy_e;
    bit vd_n;
    cyc++;
    if (!reset) begin
      mq.delete();
      idx    = 0;
      exp_vd = 1'b0;
    end else begin
      rdy_e = (mq.size() < DEPTH) && !init_start;
      check_eq("in_ready", 32'(in_ready), 32'(rdy_e));
      check_eq("vec_done", 32'(vec_done), 32'(exp_vd));
      if (vec_done) begin vd_cnt++; vd_cyc = cyc; end
      check_eq("busy", 32'(busy), 32'((mq.size() != 0) || (idx % LEN != 0) || exp_vd));
      check_eq("mem_waddr", 32'(mem_waddr), 32'(BASE + idx % LEN));
      if (mq.size() != 0) check_eq("mem_wdata", 32'(mem_wdata), 32'(mq[0]));
      vd_n = 1'b0;
      if (mem_we) begin
        check_eq("we_legal", 32'(mem_grant && !init_start && mq.size() != 0), 32'd1);
        last_waddr = mem_waddr;
        last_wdata = mem_wdata;
        if (mq.size() != 0) void'(mq.pop_front());
        wr_cyc.push_back(cyc);
        wr_total++;
        idx++;
        if (idx % LEN == 0) vd_n = 1'b1;
      end
      if (in_valid && rdy_e) begin
        mq.push_back(in_data);
        acc_total++;
      end
      if (init_start) begin
        mq.delete();
        idx  = 0;
        vd_n = 1'b0;
      end
      exp_vd = vd_n;
    end
  end

  logic [AW-1:0] w1_addr[$];
  logic [DW-1:0] w1_data[$];
  int            vd1_cnt = 0;
  bit            prev_we1 = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_we1 = 1'b0;
    end else begin
      if (vec_done1) begin
        check_eq("vd1_follows_write", 32'(prev_we1), 32'd1);
        vd1_cnt++;
      end
      if (mem_we1) begin
        w1_addr.push_back(mem_waddr1);
        w1_data.push_back(mem_wdata1);
      end
      prev_we1 = mem_we1;
    end
  end

  task automatic send(input logic [DW-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready && !init_start) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge clk); #1; end
    else check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send1(input logic [DW-1:0] d);
    bit ok = 1'b0;
    in_valid1 = 1'b1;
    in_data1  = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready1) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge clk); #1; end
    else check_eq("send1_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (mq.size() == 0 && !exp_vd) break;
      @(posedge clk); #1;
    end
    check_eq("drain_empty", 32'(mq.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int w0, a0, v0;

  initial begin
    init_start = 1'b0; in_valid = 1'b0; in_data = '0; mem_grant = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_waddr", 32'(mem_waddr), 32'(BASE));
    check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_vec_done", 32'(vec_done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_waddr1", 32'(mem_waddr1), 32'(BASE));
    reset = 1'b1;
    @(posedge clk); #1;

    // Back-to-back vector with grant held high
    mem_grant = 1'b1;
    send(16'h0011); send(16'h0022); send(16'h0033); send(16'h0044);
    in_valid = 1'b0;
    drain();
    check_eq("t1_writes", 32'(wr_total), 32'd4);
    if (wr_cyc.size() == 4) check_eq("t1_consecutive", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
    check_eq("t1_vd_cnt", 32'(vd_cnt), 32'd1);
    if (wr_cyc.size() == 4) check_eq("t1_vd_timing", 32'(vd_cyc - wr_cyc[3]), 32'd1);
    check_eq("t1_last_addr", 32'(last_waddr), 32'd8);
    check_eq("t1_last_data", 32'(last_wdata), 32'h44);

    // Backpressure: FIFO fills while grant is low
    w0 = wr_total; a0 = acc_total;
    mem_grant = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) send(DW'(16'h0100 * k));
        in_valid = 1'b0;
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        check_eq("t2_accepted", 32'(acc_total - a0), 32'd4);
        check_eq("t2_full_ready", 32'(in_ready), 32'd0);
        mem_grant = 1'b1;
      end
    join
    drain();
    check_eq("t2_writes", 32'(wr_total - w0), 32'd6);
    check_eq("t2_last_addr", 32'(last_waddr), 32'(BASE + 1));
    check_eq("t2_last_data", 32'(last_wdata), 32'h0600);
    check_eq("t2_vd_cnt", 32'(vd_cnt), 32'd2);

    // Toggling grant mid-vector
    w0 = wr_total;
    fork
      begin
        send(16'h0777); send(16'h0888);
        in_valid = 1'b0;
      end
      for (int k = 0; k < 8; k++) begin
        mem_grant = (k % 2 == 0);
        @(posedge clk); #1;
      end
    join
    mem_grant = 1'b1;
    drain();
    check_eq("t3_writes", 32'(wr_total - w0), 32'd2);
    check_eq("t3_last_addr", 32'(last_waddr), 32'd8);
    check_eq("t3_vd_cnt", 32'(vd_cnt), 32'd3);

    // init_start aborts a partially written vector
    w0 = wr_total; v0 = vd_cnt;
    mem_grant = 1'b0;
    send(16'hA001); send(16'hA002); send(16'hA003); send(16'hA004);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_grant = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (wr_total - w0 >= 2) break;
      @(posedge clk); #1;
    end
    init_start = 1'b1;
    @(posedge clk); #1;
    init_start = 1'b0;
    send(16'h1234);
    in_valid = 1'b0;
    drain();
    check_eq("t4_writes", 32'(wr_total - w0), 32'd3);
    check_eq("t4_addr", 32'(last_waddr), 32'(BASE));
    check_eq("t4_data", 32'(last_wdata), 32'h1234);
    check_eq("t4_no_vd", 32'(vd_cnt - v0), 32'd0);

    // Asynchronous reset with elements buffered mid-vector
    mem_grant = 1'b0;
    send(16'hB001); send(16'hB002); send(16'hB003);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_eq("t5_in_ready", 32'(in_ready), 32'd1);
    check_eq("t5_mem_we", 32'(mem_we), 32'd0);
    check_eq("t5_waddr", 32'(mem_waddr), 32'(BASE));
    check_eq("t5_wdata", 32'(mem_wdata), 32'd0);
    check_eq("t5_vec_done", 32'(vec_done), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit acc;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom % 3 != 0);
        in_data  = DW'($urandom);
      end
      mem_grant  = ($urandom % 4 != 0);
      init_start = ($urandom % 50 == 0);
    end
    in_valid = 1'b0; init_start = 1'b0; mem_grant = 1'b1;
    drain();

    // Single-element vectors
    send1(16'hAAAA); send1(16'hBBBB);
    in_valid1 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check_eq("t6_writes", 32'(w1_addr.size()), 32'd2);
    if (w1_addr.size() == 2) begin
      check_eq("t6_addr0", 32'(w1_addr[0]), 32'(BASE));
      check_eq("t6_addr1", 32'(w1_addr[1]), 32'(BASE));
      check_eq("t6_data0", 32'(w1_data[0]), 32'hAAAA);
      check_eq("t6_data1", 32'(w1_data[1]), 32'hBBBB);
    end
    check_eq("t6_vd_cnt", 32'(vd1_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
